// File: rtl/accel_wb_bridge.sv
// rtl/accel_wb_bridge.sv - Wishbone bridge from the network adapter master to NR_ACCEL accelerator slave ports
// Optional response timeout: define OPTIMSOC_ACCEL_TIMEOUT_EN.
module accel_wb_bridge #(
  parameter int NR_ACCEL       = 2,
  parameter int ACCEL_SEL_LSB  = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic                     wbs_we_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic [32*NR_ACCEL-1:0]   acc_adr_o,
  output logic [32*NR_ACCEL-1:0]   acc_dat_o,
  output logic [4*NR_ACCEL-1:0]    acc_sel_o,
  output logic [NR_ACCEL-1:0]      acc_we_o,
  output logic [NR_ACCEL-1:0]      acc_cyc_o,
  output logic [NR_ACCEL-1:0]      acc_stb_o,
  input  logic [32*NR_ACCEL-1:0]   acc_dat_i,
  input  logic [NR_ACCEL-1:0]      acc_ack_i,
  input  logic [NR_ACCEL-1:0]      acc_err_i,
  output logic                     busy_o,
  output logic [7:0]               err_cnt_o
);

  localparam int IW = (NR_ACCEL > 1) ? $clog2(NR_ACCEL) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [31:0]         adr_q;
  logic [31:0]         dat_q;
  logic [3:0]          sel_q;
  logic                we_q;
  logic [IW-1:0]       idx_q;
  logic [NR_ACCEL-1:0] cyc_q;

  logic [IW-1:0]       req_idx;
  logic                req_valid;
  logic                port_ack;
  logic                port_err;
  logic [31:0]         port_dat;
  logic [7:0]          err_cnt_next;
  logic                tmo_hit;

  assign req_idx      = wbs_adr_i[ACCEL_SEL_LSB +: IW];
  assign req_valid    = ({1'b0, req_idx} < (IW+1)'(NR_ACCEL));
  assign err_cnt_next = (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;
  assign busy_o       = (state != IDLE);
  assign acc_cyc_o    = cyc_q;
  assign acc_stb_o    = cyc_q;

`ifdef OPTIMSOC_ACCEL_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Held at zero outside ACCESS so every access starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tmo_cnt <= '0;
    else if (state == ACCESS) tmo_cnt <= tmo_cnt + 16'd1;
    else                      tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    acc_adr_o = '0;
    acc_dat_o = '0;
    acc_sel_o = '0;
    acc_we_o  = '0;
    port_ack  = 1'b0;
    port_err  = 1'b0;
    port_dat  = '0;
    for (int n = 0; n < NR_ACCEL; n++) begin
      if (cyc_q[n]) begin
        acc_adr_o[32*n +: 32] = adr_q;
        acc_dat_o[32*n +: 32] = dat_q;
        acc_sel_o[4*n +: 4]   = sel_q;
        acc_we_o[n]           = we_q;
      end
      if (idx_q == IW'(n)) begin
        port_ack = acc_ack_i[n];
        port_err = acc_err_i[n];
        port_dat = acc_dat_i[32*n +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      cyc_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      err_cnt_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            sel_q <= wbs_sel_i;
            we_q  <= wbs_we_i;
            idx_q <= req_idx;
            if (req_valid) begin
              state <= ACCESS;
              cyc_q <= NR_ACCEL'(1) << req_idx;
            end else begin
              state     <= RESP;
              wbs_err_o <= 1'b1;
              err_cnt_o <= err_cnt_next;
            end
          end
        end
        ACCESS: begin
          // A master abandoning the cycle takes priority over any response.
          if (!wbs_cyc_i) begin
            state <= IDLE;
            cyc_q <= '0;
          end else if (port_err || tmo_hit) begin
            state     <= RESP;
            cyc_q     <= '0;
            wbs_err_o <= 1'b1;
            err_cnt_o <= err_cnt_next;
          end else if (port_ack) begin
            state     <= RESP;
            cyc_q     <= '0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= port_dat;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_wb_bridge.sv
// tb/tb_accel_wb_bridge.sv - scoreboard bench for accel_wb_bridge with random slave timing and responses
module tb_accel_wb_bridge;
  localparam int NR  = 3;
  localparam int TMO = 4;
`ifdef OPTIMSOC_ACCEL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic [32*NR-1:0] acc_adr_o, acc_dat_o;
  logic [4*NR-1:0]  acc_sel_o;
  logic [NR-1:0]    acc_we_o, acc_cyc_o, acc_stb_o;
  logic [32*NR-1:0] acc_dat_i = '0;
  logic [NR-1:0]    acc_ack_i = '0, acc_err_i = '0;
  logic        busy_o;
  logic [7:0]  err_cnt_o;

  accel_wb_bridge #(.NR_ACCEL(NR), .ACCEL_SEL_LSB(24), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .acc_adr_o(acc_adr_o), .acc_dat_o(acc_dat_o), .acc_sel_o(acc_sel_o),
    .acc_we_o(acc_we_o), .acc_cyc_o(acc_cyc_o), .acc_stb_o(acc_stb_o),
    .acc_dat_i(acc_dat_i), .acc_ack_i(acc_ack_i), .acc_err_i(acc_err_i),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    bit          err;
    logic [31:0] dat;
    int          cyc;
    int          ecnt;
  } resp_t;

  resp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc_n = 0, model_ecnt = 0;
  bit          acc_exp_on = 1'b0;
  int          acc_exp_port = 0;
  logic [31:0] acc_exp_adr = '0, acc_exp_dat = '0;
  logic [3:0]  acc_exp_sel = '0;
  logic        acc_exp_we = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_n++; end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push_resp(input bit err, input logic [31:0] dat);
    resp_t r;
    if (err && model_ecnt < 255) model_ecnt++;
    r.err  = err;
    r.dat  = err ? 32'h0 : dat;
    r.cyc  = cyc_n + 1;
    r.ecnt = model_ecnt;
    sb.push_back(r);
  endtask

  // Monitor: accelerator-side activity and master-side responses, sampled 1ns after the edge.
  initial begin : monitor
    logic [NR-1:0] ev;
    resp_t r;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        ev = acc_exp_on ? (NR'(1) << acc_exp_port) : '0;
        chk("acc_cyc", 32'(acc_cyc_o), 32'(ev));
        chk("acc_stb", 32'(acc_stb_o), 32'(ev));
        if (acc_exp_on) begin
          chk("acc_adr", acc_adr_o[32*acc_exp_port +: 32], acc_exp_adr);
          chk("acc_dat", acc_dat_o[32*acc_exp_port +: 32], acc_exp_dat);
          chk("acc_sel", 32'(acc_sel_o[4*acc_exp_port +: 4]), 32'(acc_exp_sel));
          chk("acc_we", 32'(acc_we_o[acc_exp_port]), 32'(acc_exp_we));
        end
        if (wbs_ack_o || wbs_err_o) begin
          chk("ack_err_excl", 32'(wbs_ack_o & wbs_err_o), 32'h0);
          if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(wbs_ack_o | wbs_err_o), 32'h0);
          end else begin
            r = sb.pop_front();
            chk("resp_err", 32'(wbs_err_o), 32'(r.err));
            chk("resp_ack", 32'(wbs_ack_o), 32'(!r.err));
            chk("resp_dat", wbs_dat_o, r.dat);
            chk("resp_cycle", 32'(cyc_n), 32'(r.cyc));
            chk("err_cnt", 32'(err_cnt_o), 32'(r.ecnt));
          end
        end else begin
          chk("dat_idle_zero", wbs_dat_o, 32'h0);
        end
      end
    end
  end

  // kind: 0 ack, 1 err, 2 ack+err. delay: ACCESS cycles before responding. drop_at: ACCESS cycle index at which the master abandons (-1 never).
  task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input int kind, input int delay, input int drop_at,
                     input logic [31:0] rdat);
    int idx, cnt;
    bit done, expect_resp;
    idx = int'(adr[25:24]);
    @(negedge clk);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    expect_resp = 1'b1;
    if (idx >= NR) begin
      push_resp(1'b1, 32'h0);
    end else begin
      acc_exp_on = 1'b1; acc_exp_port = idx;
      acc_exp_adr = adr; acc_exp_dat = dat; acc_exp_sel = sel; acc_exp_we = we;
      cnt = 0; done = 1'b0;
      for (int t = 0; t < 1100 && !done; t++) begin
        @(negedge clk);
        acc_ack_i = NR'($urandom) & ~(NR'(1) << idx);
        acc_err_i = NR'($urandom) & ~(NR'(1) << idx);
        acc_dat_i = {$urandom, $urandom, $urandom};
        if (acc_cyc_o[idx]) begin
          if (cnt == 999) chk("still_busy", 32'(busy_o), 32'h1);
          if (cnt == drop_at) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            acc_exp_on = 1'b0; expect_resp = 1'b0; done = 1'b1;
          end else if (cnt == delay) begin
            acc_dat_i[32*idx +: 32] = rdat;
            acc_ack_i[idx] = (kind != 1);
            acc_err_i[idx] = (kind != 0);
            acc_exp_on = 1'b0;
            push_resp(kind != 0, rdat);
            done = 1'b1;
          end else if (TMO_EN && cnt == TMO - 1) begin
            acc_exp_on = 1'b0;
            push_resp(1'b1, 32'h0);
            done = 1'b1;
          end
          cnt++;
        end
      end
      if (!done) begin
        chk("slave_wait", 32'h0, 32'h1);
        acc_exp_on = 1'b0; expect_resp = 1'b0;
      end
    end
    if (expect_resp) begin
      done = 1'b0;
      for (int t = 0; t < 10 && !done; t++) begin
        @(negedge clk);
        acc_ack_i = '0; acc_err_i = '0;
        if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
        chk("resp_wait", 32'(sb.size()), 32'h0);
        sb.delete();
      end
    end else begin
      @(negedge clk);
      acc_ack_i = '0; acc_err_i = '0;
      chk("abort_idle", 32'(busy_o), 32'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int k, d, dr;
    repeat (2) @(negedge clk);
    chk("rst_acc_cyc", 32'(acc_cyc_o), 32'h0);
    chk("rst_acc_adr", 32'(acc_adr_o != '0), 32'h0);
    chk("rst_ack", 32'(wbs_ack_o | wbs_err_o), 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt_o), 32'h0);
    rst = 1'b0;

    txn(32'h0100_0010, 32'hDEADBEEF, 4'hF, 1'b1, 0, 1, -1, 32'h0);
    txn(32'h0000_0004, 32'h0, 4'hF, 1'b0, 0, 0, -1, 32'h1234_5678);
    txn(32'h0300_0000, 32'h0, 4'hF, 1'b0, 0, 0, -1, 32'h0);
    txn(32'h0000_0020, 32'h0, 4'h3, 1'b0, 2, 0, -1, 32'hCAFE_F00D);
    txn(32'h0000_0040, 32'h0, 4'hF, 1'b0, 0, 1000, -1, 32'h55AA_55AA);
    txn(32'h0100_0000, 32'h1111_2222, 4'hF, 1'b1, 0, 5, 1, 32'h0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      k = $urandom_range(0, 9);
      k = (k < 6) ? 0 : (k < 8) ? 1 : 2;
      d = $urandom_range(0, 6);
      dr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, d) : -1;
      txn(a, $urandom, 4'($urandom), 1'($urandom), k, d, dr, $urandom);
    end

    for (int i = 0; i < 258; i++)
      txn({6'($urandom), 2'b11, 24'($urandom)}, $urandom, 4'hF, 1'b0, 0, 0, -1, 32'h0);
    chk("err_cnt_sat", 32'(err_cnt_o), 32'd255);

    @(negedge clk);
    wbs_adr_i = 32'h0200_0008; wbs_dat_i = 32'hA5A5_0000; wbs_sel_i = 4'hF; wbs_we_i = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    acc_exp_on = 1'b1; acc_exp_port = 2;
    acc_exp_adr = 32'h0200_0008; acc_exp_dat = 32'hA5A5_0000; acc_exp_sel = 4'hF; acc_exp_we = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", 32'(acc_cyc_o), 32'h4);
    rst = 1'b1; acc_exp_on = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(acc_cyc_o | acc_stb_o), 32'h0);
    chk("rst_async_busy", 32'(busy_o), 32'h0);
    chk("rst_async_err_cnt", 32'(err_cnt_o), 32'h0);
    model_ecnt = 0;
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy_o), 32'h0);
    chk("post_rst_err_cnt", 32'(err_cnt_o), 32'h0);

    txn(32'h0300_0004, 32'h0, 4'hF, 1'b0, 0, 0, -1, 32'h0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
